// File: rtl/computer_pkg.sv
// Shared definitions for the Computer node: RAM geometry and the data-RAM
// port arbiter state encoding.
package computer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDATA
  } arb_state_t;

endpackage

// File: rtl/dm_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate strictly after `last`
// in circular order, returned one-hot with a found flag.
module rr_pick #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0]         cand,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         winner_c,
  output logic                     found_c
);

  localparam int unsigned LW = $clog2(N_REQ);

  // Offset 1..N_REQ so `last` itself is considered only after everyone else.
  always_comb begin
    winner_c = '0;
    found_c  = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!found_c && cand[LW'((32'(last) + k) % N_REQ)]) begin
        winner_c[LW'((32'(last) + k) % N_REQ)] = 1'b1;
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port data RAM arbiter: round-robin grants with an optional
// read-modify-write lock; all RAM-side signals and read returns are registered.
module dm_port_arbiter
  import computer_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = computer_pkg::ADDR_W,
  parameter int unsigned DATA_W = computer_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0]              lock,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int unsigned LW = $clog2(N_REQ);

  arb_state_t        state, state_d;
  logic [LW-1:0]     last, last_d;
  logic [LW-1:0]     owner, owner_d;
  logic              locked, locked_d;
  logic [N_REQ-1:0]  gnt_d, rd_valid_d;
  logic [DATA_W-1:0] rd_data_d, ram_wdata_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              ram_we_d;

  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  win_oh;
  logic              found;
  logic [LW-1:0]     win_idx;

  // A held lock narrows the field to the owner; once the owner lets go of req
  // the lock no longer applies, so others may win on that same edge.
  always_comb begin
    cand = req;
    if (locked && req[owner]) begin
      cand        = '0;
      cand[owner] = 1'b1;
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .cand     (cand),
    .last     (last),
    .winner_c (win_oh),
    .found_c  (found)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) win_idx = LW'(i);
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state;
    gnt_d       = '0;
    rd_valid_d  = '0;
    rd_data_d   = rd_data;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    ram_we_d    = 1'b0;
    last_d      = last;
    owner_d     = owner;
    locked_d    = locked;
    case (state)
      IDLE: begin
        if (locked && !req[owner]) locked_d = 1'b0;
        if (found) begin
          gnt_d       = win_oh;
          ram_addr_d  = addr[win_idx];
          ram_wdata_d = wdata[win_idx];
          ram_we_d    = we[win_idx];
          last_d      = win_idx;
          owner_d     = win_idx;
          locked_d    = lock[win_idx];
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // ram_we still reflects the access the RAM performs at this edge.
        state_d = ram_we ? IDLE : RDATA;
      end
      RDATA: begin
        rd_data_d         = ram_rdata;
        rd_valid_d[owner] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      last      <= LW'(N_REQ - 1);
      owner     <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      ram_we    <= ram_we_d;
      last      <= last_d;
      owner     <= owner_d;
      locked    <= locked_d;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: 2-requester instance on a behavioural
// synchronous RAM, plus a 4-requester instance for grant ordering.
module tb_dm_port_arbiter;

  logic             clk;
  logic             rst;
  logic             mem_clr;
  logic [1:0]       req, we, lock;
  logic [1:0][15:0] addr, wdata;
  logic [1:0]       gnt, rd_valid;
  logic [15:0]      rd_data, ram_addr, ram_wdata, ram_rdata;
  logic             ram_we;

  logic [3:0]       req4, we4, lock4;
  logic [3:0][15:0] addr4, wdata4;
  logic [3:0]       gnt4, rd_valid4;
  logic [15:0]      rd_data4, ram_addr4, ram_wdata4, ram_rdata4;
  logic             ram_we4;

  logic [15:0]      mem [256];
  logic [255:0]     written;

  int checks = 0;
  int fails  = 0;
  int cnt0, cnt1;
  int unsigned ord_a [5] = '{0, 1, 2, 3, 0};
  int unsigned ord_b [4] = '{0, 1, 3, 0};
  logic [3:0] exp4;

  assign ram_rdata4 = 16'h0000;

  dm_port_arbiter #(.N_REQ(2), .ADDR_W(16), .DATA_W(16)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  dm_port_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .we(we4), .lock(lock4), .addr(addr4),
    .wdata(wdata4), .gnt(gnt4), .rd_valid(rd_valid4), .rd_data(rd_data4),
    .ram_addr(ram_addr4), .ram_wdata(ram_wdata4), .ram_we(ram_we4),
    .ram_rdata(ram_rdata4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read; unwritten words read as {A5, addr[7:0]}.
  always @(posedge clk) begin
    if (mem_clr) begin
      written <= '0;
    end else if (ram_we) begin
      mem[ram_addr[7:0]]     <= ram_wdata;
      written[ram_addr[7:0]] <= 1'b1;
    end
    ram_rdata <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : {8'hA5, ram_addr[7:0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    req4 = '0; we4 = '0; lock4 = '0; wdata4 = '0;
    for (int i = 0; i < 4; i++) addr4[i] = 16'h0100 + 16'(i);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_rd_data4", 32'(rd_data4), 32'h0);
    tick(); tick();
    rst = 1'b0; mem_clr = 1'b0;

    // Single write then read-back
    req = 2'b01; we = 2'b01; addr[0] = 16'h0010; wdata[0] = 16'hBEEF;
    tick();
    check("wr_gnt", 32'(gnt), 32'h1);
    check("wr_ram_we", 32'(ram_we), 32'h1);
    check("wr_ram_addr", 32'(ram_addr), 32'h0010);
    check("wr_ram_wdata", 32'(ram_wdata), 32'hBEEF);
    req = '0;
    tick();
    check("wr_gnt_clr", 32'(gnt), 32'h0);
    check("wr_we_clr", 32'(ram_we), 32'h0);
    check("wr_addr_hold", 32'(ram_addr), 32'h0010);
    req = 2'b01; we = 2'b00;
    tick();
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_ram_we", 32'(ram_we), 32'h0);
    req = '0;
    tick();
    check("rd_valid_e1", 32'(rd_valid), 32'h0);
    tick();
    check("rd_valid_e2", 32'(rd_valid), 32'h1);
    check("rd_data_e2", 32'(rd_data), 32'hBEEF);
    tick();
    check("rd_valid_e3", 32'(rd_valid), 32'h0);

    // Simultaneous reads after reset
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11; we = 2'b00; addr[0] = 16'h0020; addr[1] = 16'h0030;
    tick();
    check("sim_gnt0", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    tick();
    check("sim_gap1", 32'(gnt), 32'h0);
    tick();
    check("sim_gap2", 32'(gnt), 32'h0);
    check("sim_rv0", 32'(rd_valid), 32'h1);
    check("sim_rd0", 32'(rd_data), 32'hA520);
    tick();
    check("sim_gnt1", 32'(gnt), 32'h2);
    check("sim_rv_clr", 32'(rd_valid), 32'h0);
    req[1] = 1'b0;
    tick();
    tick();
    check("sim_rv1", 32'(rd_valid), 32'h2);
    check("sim_rd1", 32'(rd_data), 32'hA530);

    // Fairness over 12 back-to-back writes
    req = 2'b11; we = 2'b11; addr[0] = 16'h0080; addr[1] = 16'h0081;
    wdata[0] = 16'h0A0A; wdata[1] = 16'h0B0B;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("fair_gnt_%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (gnt[0]) cnt0++;
      if (gnt[1]) cnt1++;
      tick();
      check($sformatf("fair_gap_%0d", k), 32'(gnt), 32'h0);
    end
    req = '0; we = '0;
    check("fair_cnt0", 32'(cnt0), 32'd6);
    check("fair_cnt1", 32'(cnt1), 32'd6);

    // Lock held across read-modify-write by requester 1
    req = 2'b10; we = 2'b00; lock = 2'b10; addr[1] = 16'h0050;
    tick();
    check("lk_gnt1_rd", 32'(gnt), 32'h2);
    req = 2'b11; we = 2'b11; lock = 2'b00;
    addr[0] = 16'h0090; wdata[0] = 16'h9090; wdata[1] = 16'h5555;
    tick();
    check("lk_access", 32'(gnt), 32'h0);
    tick();
    check("lk_rdata_gnt", 32'(gnt), 32'h0);
    check("lk_rv", 32'(rd_valid), 32'h2);
    check("lk_rd", 32'(rd_data), 32'hA550);
    tick();
    check("lk_gnt1_wr", 32'(gnt), 32'h2);
    check("lk_wr_addr", 32'(ram_addr), 32'h0050);
    check("lk_wr_we", 32'(ram_we), 32'h1);
    req[1] = 1'b0;
    tick();
    check("lk_wr_access", 32'(gnt), 32'h0);
    tick();
    check("lk_gnt0", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    tick();
    req = 2'b10; we = 2'b00; lock = 2'b10; addr[1] = 16'h0050;
    tick();
    check("lk2_gnt1", 32'(gnt), 32'h2);
    req = 2'b01; we = 2'b01; lock = 2'b00;
    tick();
    tick();
    check("lk2_rv", 32'(rd_valid), 32'h2);
    check("lk2_rd", 32'(rd_data), 32'h5555);
    tick();
    check("lk2_drop_gnt0", 32'(gnt), 32'h1);
    req = '0; we = '0;
    tick();

    // Reset during the RDATA cycle, then during a write grant
    req = 2'b10; addr[1] = 16'h0030;
    tick();
    check("rr_gnt1", 32'(gnt), 32'h2);
    req = '0;
    tick();
    rst = 1'b1;
    #1;
    check("rr_gnt", 32'(gnt), 32'h0);
    check("rr_rv", 32'(rd_valid), 32'h0);
    check("rr_rd_data", 32'(rd_data), 32'h0);
    check("rr_ram_addr", 32'(ram_addr), 32'h0);
    check("rr_ram_wdata", 32'(ram_wdata), 32'h0);
    check("rr_ram_we", 32'(ram_we), 32'h0);
    tick();
    check("rr_rv_after", 32'(rd_valid), 32'h0);
    rst = 1'b0;
    req = 2'b11; we = 2'b11; addr[0] = 16'h0060; wdata[0] = 16'h6666; addr[1] = 16'h0070;
    tick();
    check("rw_gnt0_first", 32'(gnt), 32'h1);
    check("rw_we_set", 32'(ram_we), 32'h1);
    rst = 1'b1;
    #1;
    check("rw_we_async", 32'(ram_we), 32'h0);
    tick();
    check("rw_no_write", 32'(written[8'h60]), 32'h0);
    req = '0; we = '0;
    rst = 1'b0;

    // Four requesters, all requesting writes
    req4 = 4'b1111; we4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp4 = 4'b0001 << ord_a[k];
      check($sformatf("n4a_gnt_%0d", k), 32'(gnt4), 32'(exp4));
      check($sformatf("n4a_addr_%0d", k), 32'(ram_addr4), 32'h0100 + ord_a[k]);
      check($sformatf("n4a_we_%0d", k), 32'(ram_we4), 32'h1);
      tick();
      check($sformatf("n4a_gap_%0d", k), 32'(gnt4), 32'h0);
    end
    req4 = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    req4 = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp4 = 4'b0001 << ord_b[k];
      check($sformatf("n4b_gnt_%0d", k), 32'(gnt4), 32'(exp4));
      check($sformatf("n4b_rv_%0d", k), 32'(rd_valid4), 32'h0);
      tick();
    end
    req4 = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
